// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Shadows the EX/MEM and MEM/WB destination/write-enable pairs. From these it
// derives the ALU operand forwarding selects, the load-use stall and a
// saturating stall counter used for performance debug.
module fwd_hazard_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [4:0]             ifid_rs_i,
  input  logic [4:0]             ifid_rt_i,
  input  logic [4:0]             idex_rs_i,
  input  logic [4:0]             idex_rt_i,
  input  logic [4:0]             idex_dst_i,
  input  logic                   idex_regwrite_i,
  input  logic                   idex_memread_i,
  output logic [1:0]             forwardA_o,
  output logic [1:0]             forwardB_o,
  output logic                   stall_o,
  output logic                   pc_write_o,
  output logic                   ifid_write_o,
  output logic [4:0]             exmem_dst_o,
  output logic [4:0]             memwb_dst_o,
  output logic [STALL_CNT_W-1:0] stall_count_o
);

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  logic [4:0]             r_exmem_dst;
  logic                   r_exmem_rw;
  logic [4:0]             r_memwb_dst;
  logic                   r_memwb_rw;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic                   w_exmem_live;
  logic                   w_memwb_live;
  logic                   w_stall;
  logic                   w_cnt_full;
  logic [1:0]             w_fwd_a;
  logic [1:0]             w_fwd_b;

  // A stage is a valid forwarding source only if it writes a register other than $0.
  assign w_exmem_live = r_exmem_rw && (r_exmem_dst != 5'd0);
  assign w_memwb_live = r_memwb_rw && (r_memwb_dst != 5'd0);

  // The newest producer (EX/MEM) takes priority over the older one (MEM/WB).
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       exmem_live,
                                         input logic [4:0] exmem_dst,
                                         input logic       memwb_live,
                                         input logic [4:0] memwb_dst);
    logic [1:0] sel;
    sel = FWD_IDEX;
    if (exmem_live && (exmem_dst == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_live && (memwb_dst == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  // Operand selects for both ALU inputs, valid in the same cycle as the ID/EX fields.
  always_comb begin
    w_fwd_a = fwd_sel(idex_rs_i, w_exmem_live, r_exmem_dst, w_memwb_live, r_memwb_dst);
    w_fwd_b = fwd_sel(idex_rt_i, w_exmem_live, r_exmem_dst, w_memwb_live, r_memwb_dst);
  end

  // Load in ID/EX whose destination is read by the instruction in IF/ID.
  // Purely combinational, so it also tracks its inputs while reset is held.
  assign w_stall = idex_memread_i && (idex_dst_i != 5'd0) &&
                   ((idex_dst_i == ifid_rs_i) || (idex_dst_i == ifid_rt_i));

  assign w_cnt_full = &r_stall_cnt;

  // Shadow pipeline: the ID/EX producer always advances, even on a stall cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_exmem_dst <= 5'd0;
      r_exmem_rw  <= 1'b0;
      r_memwb_dst <= 5'd0;
      r_memwb_rw  <= 1'b0;
    end else begin
      r_exmem_dst <= idex_dst_i;
      r_exmem_rw  <= idex_regwrite_i;
      r_memwb_dst <= r_exmem_dst;
      r_memwb_rw  <= r_exmem_rw;
    end
  end

  // Saturating count of stall cycles; sticks at all-ones rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_cnt_full) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign forwardA_o    = w_fwd_a;
  assign forwardB_o    = w_fwd_b;
  assign stall_o       = w_stall;
  assign pc_write_o    = !w_stall;
  assign ifid_write_o  = !w_stall;
  assign exmem_dst_o   = r_exmem_dst;
  assign memwb_dst_o   = r_memwb_dst;
  assign stall_count_o = r_stall_cnt;

endmodule
